hlsm_sum_match: RTL
===================

# hlsm_sum_match

Parametrised successor to the 4-bit sum-match HLSM. On a `b` request the block captures two operands and a target, checks whether the operands sum exactly to the target, and if so presents the operands on registered outputs until `b` is dropped. It sits as a small compute FSM between an upstream requester (holding `b` high) and downstream logic that consumes `Do`/`Eo` along with new `done`/`match` status.

## Interface
- `WIDTH`, default 4, sets the operand, target and output width (WIDTH ≥ 2).
- `CNT_W`, default 8, sets the match counter width; used only with `HLSM_MATCH_CNT_EN`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `b`  in  1  request; level-sensitive, held high for the whole transaction.
- `Di`  in  WIDTH  operand D.
- `Ei`  in  WIDTH  operand E.
- `F`  in  WIDTH  target sum.
- `Do`  out  WIDTH  registered D result; reset 0.
- `Eo`  out  WIDTH  registered E result; reset 0.
- `done`  out  1  high in HOLD; reset 0.
- `match`  out  1  high in HOLD when the check passed; reset 0.
- `match_cnt`  out  CNT_W  count of passed checks; reset 0; present only with `HLSM_MATCH_CNT_EN`.

## Operation
- States (2-bit encoding): WAIT=00, LOAD=01, CHECK=10, HOLD=11.
- WAIT: `Do`/`Eo`/`done`/`match` are 0. Move to LOAD when `b`=1; otherwise stay.
- LOAD: capture `Di`, `Ei`, `F` into internal registers `d_r`, `e_r`, `f_r`, then move to CHECK. If `b`=0, go to WAIT with no capture.
- CHECK: compute the sum as `{1'b0,d_r}+{1'b0,e_r}` (WIDTH+1 bits) and compare it to `{1'b0,f_r}`. The carry is kept, so a wrapped sum never matches.
  - Equal: `Do`<=`d_r`, `Eo`<=`e_r`, `match`<=1.
  - Unequal: `Do`/`Eo` stay 0 and `match`<=0.
  - In both cases set `done`<=1 and go to HOLD.
  - If `b`=0 in CHECK, go to WAIT; outputs are not updated.
- HOLD: outputs are frozen. When `b`=0, go to WAIT and clear `Do`, `Eo`, `done` and `match` on that same edge. Input changes during HOLD are ignored.
- Input changes after the LOAD edge never affect the current transaction.
- A new transaction needs `b` low for at least one edge so the FSM returns to WAIT first. Holding `b` continuously high does not retrigger.
- `rst` has priority in every state. Next edge: state=WAIT, all outputs and internal registers 0, `match_cnt` 0.

## Timing
- The `b` rise is sampled at edge N (WAIT→LOAD).
- Edge N+1: operands captured (LOAD→CHECK).
- Edge N+2: outputs, `done` and `match` valid (CHECK→HOLD). Latency from first sampled `b` to valid output is 3 edges.
- The edge where `b` is seen low in HOLD clears the outputs. The FSM is in WAIT after that edge and can accept `b` on the following edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `HLSM_MATCH_CNT_EN` defined:
  - `match_cnt` port exists.
  - It increments by 1 on every CHECK→HOLD edge with `match`=1.
  - It saturates at 2^CNT_W−1 and is cleared only by `rst`.
- Undefined: no counter logic and no `match_cnt` port. FSM behaviour is identical.

## Structure
- `hlsm_pkg`: state typedef and encodings (WAIT/LOAD/CHECK/HOLD), and the `WIDTH`/`CNT_W` default constants.
- One sub-module, `hlsm_match_counter` (saturating, parameter `CNT_W`, inputs `clk`, `rst`, `inc`). It is instantiated only under `HLSM_MATCH_CNT_EN`.

## Test plan
- Reset: `rst`=1 for one edge → `Do`=0, `Eo`=0, `done`=0, `match`=0 (and `match_cnt`=0).
- Mismatch, WIDTH=4: Di=2, Ei=4, F=2, `b`=1 → 0 after edges N and N+1. After N+2: `Do`=0, `Eo`=0, `done`=1, `match`=0. Drop `b` → all 0 one edge later.
- Match, WIDTH=4: Di=2, Ei=4, F=6, `b`=1 → 0 after N+1. After N+2: `Do`=2, `Eo`=4, `match`=1. Change Di to 7 in HOLD → `Do` stays 2. `b`=0 → `Do`=0, `Eo`=0.
- Wrap: WIDTH=4, Di=9, Ei=9, F=2 (9+9=18, low bits 2) → `match`=0, `Do`=0.
- Abort and idle: `b` high at N, low before N+1 → back in WAIT, outputs stay 0. With `b`=0 throughout, no state change.
- Counter/saturation (`HLSM_MATCH_CNT_EN`, CNT_W=2): 4 matching transactions → `match_cnt`=3. A mismatch transaction does not increment. `rst` asserted mid-CHECK → outputs 0 and `match_cnt`=0 on the next edge.

Source files
------------

// File: rtl/hlsm_pkg.sv
// ---------------------------------------------------------------------------
// hlsm_pkg
//   Shared definitions for the sum-match HLSM: FSM state encoding and the
//   default operand / counter widths used by hlsm_sum_match and
//   hlsm_match_counter.
// ---------------------------------------------------------------------------
package hlsm_pkg;

    // Default operand, target and output width.
    localparam int unsigned HLSM_WIDTH = 4;

    // Default match counter width (only meaningful with HLSM_MATCH_CNT_EN).
    localparam int unsigned HLSM_CNT_W = 8;

    // FSM states; the encoding is fixed so the state can be probed in a lab.
    typedef enum logic [1:0] {
        ST_WAIT  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_CHECK = 2'b10,
        ST_HOLD  = 2'b11
    } hlsm_state_e;

endpackage : hlsm_pkg

// File: rtl/hlsm_match_counter.sv
// ---------------------------------------------------------------------------
// hlsm_match_counter
//   Saturating up-counter of successful sum checks. Instantiated by
//   hlsm_sum_match only when HLSM_MATCH_CNT_EN is defined.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset, clears the count
//   inc    in   add one this edge (ignored once the count is all ones)
//   count  out  CNT_W-bit registered count
// ---------------------------------------------------------------------------
module hlsm_match_counter
    import hlsm_pkg::*;
#(
    parameter int unsigned CNT_W = HLSM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Stick at all ones instead of wrapping back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule : hlsm_match_counter

// File: rtl/hlsm_sum_match.sv
// ---------------------------------------------------------------------------
// hlsm_sum_match
//   Four-state HLSM (WAIT -> LOAD -> CHECK -> HOLD). While b is held high it
//   captures Di/Ei/F, checks Di+Ei == F with the carry kept (a wrapped sum
//   never matches), and on success presents the operands on Do/Eo until b is
//   dropped. done/match report the result while in HOLD.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, priority over everything
//   b          in   request, level-sensitive, high for the whole transaction
//   Di, Ei     in   WIDTH-bit operands
//   F          in   WIDTH-bit target sum
//   Do, Eo     out  registered operands on a match, else 0
//   done       out  high in HOLD
//   match_cnt  out  CNT_W-bit saturating count of passed checks
//                   (only when HLSM_MATCH_CNT_EN is defined)
//   match      out  high in HOLD when the check passed
//
// Build option
//   HLSM_MATCH_CNT_EN  adds the match_cnt port and hlsm_match_counter.
// ---------------------------------------------------------------------------
module hlsm_sum_match
    import hlsm_pkg::*;
#(
    parameter int unsigned WIDTH = HLSM_WIDTH,
    parameter int unsigned CNT_W = HLSM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b,
    input  logic [WIDTH-1:0] Di,
    input  logic [WIDTH-1:0] Ei,
    input  logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] Do,
    output logic [WIDTH-1:0] Eo,
    output logic             done,
`ifdef HLSM_MATCH_CNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             match
);

    // Elaboration-time parameter sanity.
    if (WIDTH < 2) begin : g_bad_width
        $error("hlsm_sum_match: WIDTH must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hlsm_sum_match: CNT_W must be >= 1");
    end

    hlsm_state_e      state_q,  state_d;
    logic [WIDTH-1:0] d_r_q,    d_r_d;
    logic [WIDTH-1:0] e_r_q,    e_r_d;
    logic [WIDTH-1:0] f_r_q,    f_r_d;
    logic [WIDTH-1:0] do_q,     do_d;
    logic [WIDTH-1:0] eo_q,     eo_d;
    logic             done_q,   done_d;
    logic             match_q,  match_d;
    logic             match_inc;

    // One extra bit holds the carry, so e.g. 9+9 (=18) cannot equal 2.
    logic [WIDTH:0] sum;
    logic           sum_ok;

    assign sum    = {1'b0, d_r_q} + {1'b0, e_r_q};
    assign sum_ok = (sum == {1'b0, f_r_q});

    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d   = state_q;
        d_r_d     = d_r_q;
        e_r_d     = e_r_q;
        f_r_d     = f_r_q;
        do_d      = do_q;
        eo_d      = eo_q;
        done_d    = done_q;
        match_d   = match_q;
        match_inc = 1'b0;

        unique case (state_q)
            ST_WAIT: begin
                if (b) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (b) begin
                    d_r_d   = Di;
                    e_r_d   = Ei;
                    f_r_d   = F;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_CHECK: begin
                if (b) begin
                    done_d  = 1'b1;
                    state_d = ST_HOLD;
                    if (sum_ok) begin
                        do_d      = d_r_q;
                        eo_d      = e_r_q;
                        match_d   = 1'b1;
                        match_inc = 1'b1;
                    end else begin
                        do_d    = '0;
                        eo_d    = '0;
                        match_d = 1'b0;
                    end
                end else begin
                    // Aborted before the result was produced; outputs are
                    // still the zeros left by WAIT.
                    state_d = ST_WAIT;
                end
            end

            ST_HOLD: begin
                // Results stay frozen until the requester lets go of b.
                if (!b) begin
                    state_d = ST_WAIT;
                    do_d    = '0;
                    eo_d    = '0;
                    done_d  = 1'b0;
                    match_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= ST_WAIT;
            // NOTE: the operand registers are cleared as well so the block
            // comes out of reset in a fully known state.
            d_r_q   <= '0;
            e_r_q   <= '0;
            f_r_q   <= '0;
            do_q    <= '0;
            eo_q    <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d_r_q   <= d_r_d;
            e_r_q   <= e_r_d;
            f_r_q   <= f_r_d;
            do_q    <= do_d;
            eo_q    <= eo_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    assign Do    = do_q;
    assign Eo    = eo_q;
    assign done  = done_q;
    assign match = match_q;

`ifdef HLSM_MATCH_CNT_EN
    hlsm_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_inc),
        .count (match_cnt)
    );
`else
    // Without the counter the increment strobe has no consumer.
    logic unused_match_inc;
    assign unused_match_inc = match_inc;
`endif

endmodule : hlsm_sum_match
